// File: rtl/ifu_seq.sv
// Instruction fetch sequencer: walks a fetch PC through instruction memory and
// presents one registered word per cycle. Optional halt-on-syscall: IFU_SEQ_HALT_EN.
module ifu_seq (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt,
  output logic        halted
);

  // Output handshake: instr/instr_pc are transferred on any rising edge where
  // instr_valid & instr_ready; while valid and not ready they hold steady.

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] SYSCALL  = 32'h0000_000C;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] instr_n, instr_pc_n, fetch_cnt_n;
  logic        instr_valid_n;
  logic        handshake, load;
  logic        unused_pc_bits;

  assign im_addr        = fpc[11:2];
  assign handshake      = instr_valid & instr_ready;
  assign load           = (state == RUN) & (~instr_valid | instr_ready);
  assign unused_pc_bits = ^redirect_pc[1:0];

`ifdef IFU_SEQ_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    fpc_n         = fpc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fetch_cnt_n   = fetch_cnt;

    // A consumed word drops out unless a load below replaces it.
    if (handshake) begin
      instr_valid_n = 1'b0;
      fetch_cnt_n   = fetch_cnt + 32'd1;
    end

    case (state)
      IDLE: state_n = RUN;
      RUN: begin
        if (load && !redirect) begin
          instr_n       = im_dout;
          instr_pc_n    = fpc;
          instr_valid_n = 1'b1;
          fpc_n         = fpc + 32'd4;
`ifdef IFU_SEQ_HALT_EN
          if (im_dout == SYSCALL) state_n = HALT;
`endif
        end
      end
      HALT: if (redirect) state_n = RUN;
      default: state_n = IDLE;
    endcase

    // Redirect wins over any load and flushes the presented word.
    if (redirect) begin
      fpc_n         = {redirect_pc[31:2], 2'b00};
      instr_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      state       <= state_n;
      fpc         <= fpc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fetch_cnt   <= fetch_cnt_n;
    end
  end

endmodule

// File: tb/tb_ifu_seq.sv
// Bench for ifu_seq: behavioural instruction memory, a scoreboard of expected
// {pc, word} pairs popped at each handshake, and directed scenario tasks.
module tb_ifu_seq;

  logic        clk;
  logic        rst_n;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;
  logic        halted;

  logic [31:0] mem [1024];
  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          hs_cnt;

  ifu_seq dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_dout(im_dout),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt), .halted(halted)
  );

  assign im_dout = mem[im_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic push_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem[pc[11:2]]});
  endtask

  // One clock: scoreboard pop at the negedge if a handshake is pending, then
  // return just after the next rising edge so inputs can be driven.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (instr_valid && instr_ready) begin
      hs_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no transfer", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got pc=%h instr=%h, expected pc=%h instr=%h",
                   instr_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({instr_valid, halted, instr, instr_pc, fetch_cnt, im_addr} !== {2'b00, 96'd0, 10'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b h=%b instr=%h pc=%h cnt=%h ia=%h, expected all zero",
               instr_valid, halted, instr, instr_pc, fetch_cnt, im_addr);
    end
    rst_n = 1'b1;
    instr_ready = 1'b1;
    push_pc(32'h3000); push_pc(32'h3004); push_pc(32'h3008);
    cycle();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_cycle_valid: got %b expected 0", instr_valid);
    end
    cycle();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h3000) begin
      n_fail++; $display("FAIL first_word: got v=%b pc=%h expected v=1 pc=00003000", instr_valid, instr_pc);
    end
    cycle();
    n_checks++;
    if (instr_pc !== 32'h3004) begin
      n_fail++; $display("FAIL stream_pc1: got %h expected 00003004", instr_pc);
    end
    cycle();
    n_checks++;
    if (instr_pc !== 32'h3008) begin
      n_fail++; $display("FAIL stream_pc2: got %h expected 00003008", instr_pc);
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (instr_pc !== 32'h3008 || instr !== mem[2] || im_addr !== 10'h003 ||
          instr_valid !== 1'b1 || fetch_cnt !== 32'(hs_cnt)) begin
        n_fail++;
        $display("FAIL stall_hold: got pc=%h instr=%h ia=%h v=%b cnt=%0d expected pc=00003008 instr=%h ia=003 v=1 cnt=%0d",
                 instr_pc, instr, im_addr, instr_valid, fetch_cnt, mem[2], hs_cnt);
      end
    end
    instr_ready = 1'b1;
    cycle();
    n_checks++;
    if (instr_pc !== 32'h300C || fetch_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stall_resume: got pc=%h cnt=%0d expected pc=0000300c cnt=3", instr_pc, fetch_cnt);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect();
    redirect = 1'b1;
    redirect_pc = 32'h0000_3107;
    cycle();
    redirect = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || im_addr !== 10'h041 || fetch_cnt !== 32'd3) begin
      n_fail++; $display("FAIL redirect_flush: got v=%b ia=%h cnt=%0d expected v=0 ia=041 cnt=3", instr_valid, im_addr, fetch_cnt);
    end
    instr_ready = 1'b1;
    push_pc(32'h3104); push_pc(32'h3108);
    cycle();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h3104) begin
      n_fail++; $display("FAIL redirect_target: got v=%b pc=%h expected v=1 pc=00003104", instr_valid, instr_pc);
    end
    cycle();
    // Redirect while 0x3108 is being accepted: the handshake must count.
    redirect = 1'b1;
    redirect_pc = 32'h0000_3FFC;
    cycle();
    redirect = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || im_addr !== 10'h3FF || fetch_cnt !== 32'd5) begin
      n_fail++; $display("FAIL redirect_with_hs: got v=%b ia=%h cnt=%0d expected v=0 ia=3ff cnt=5", instr_valid, im_addr, fetch_cnt);
    end
  endtask

  task automatic test_wrap();
    push_pc(32'h3FFC); push_pc(32'h4000); push_pc(32'h4004);
    cycle();
    n_checks++;
    if (instr_pc !== 32'h3FFC || im_addr !== 10'h000) begin
      n_fail++; $display("FAIL wrap_addr: got pc=%h ia=%h expected pc=00003ffc ia=000", instr_pc, im_addr);
    end
    cycle();
    n_checks++;
    if (instr_pc !== 32'h4000 || instr !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL wrap_word: got pc=%h instr=%h expected pc=00004000 instr=a5a50000", instr_pc, instr);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    int budget;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 48; i++) push_pc(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 30; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    budget = 80;
    instr_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    instr_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || fetch_cnt !== 32'(hs_cnt)) begin
      n_fail++; $display("FAIL random_drain: got left=%0d cnt=%0d expected left=0 cnt=%0d", exp_q.size(), fetch_cnt, hs_cnt);
    end
  endtask

  task automatic test_halt();
    int base;
    mem[3] = 32'h0000_000C;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    cycle();
    redirect = 1'b0;
    instr_ready = 1'b1;
    base = hs_cnt;
    push_pc(32'h3000); push_pc(32'h3004); push_pc(32'h3008); push_pc(32'h300C);
    repeat (4) cycle();
    n_checks++;
    if (instr_pc !== 32'h300C || instr !== 32'h0000_000C) begin
      n_fail++; $display("FAIL syscall_present: got pc=%h instr=%h expected pc=0000300c instr=0000000c", instr_pc, instr);
    end
    cycle();
`ifdef IFU_SEQ_HALT_EN
    n_checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b1 || fetch_cnt !== 32'(base + 4)) begin
      n_fail++; $display("FAIL halt_enter: got v=%b h=%b cnt=%0d expected v=0 h=1 cnt=%0d", instr_valid, halted, fetch_cnt, base + 4);
    end
    cycle();
    n_checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold: got v=%b h=%b expected v=0 h=1", instr_valid, halted);
    end
    redirect = 1'b1;
    cycle();
    redirect = 1'b0;
    instr_ready = 1'b0;
    cycle();
    n_checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h3000) begin
      n_fail++; $display("FAIL halt_resume: got h=%b v=%b pc=%h expected h=0 v=1 pc=00003000", halted, instr_valid, instr_pc);
    end
`else
    n_checks++;
    if (instr_pc !== 32'h3010 || halted !== 1'b0 || fetch_cnt !== 32'(base + 4)) begin
      n_fail++; $display("FAIL no_halt: got pc=%h h=%b cnt=%0d expected pc=00003010 h=0 cnt=%0d", instr_pc, halted, fetch_cnt, base + 4);
    end
`endif
    instr_ready = 1'b0;
    mem[3] = 32'hA5A5_0003;
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({instr_valid, halted, instr, instr_pc, fetch_cnt, im_addr} !== {2'b00, 96'd0, 10'h000}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b h=%b instr=%h pc=%h cnt=%h ia=%h, expected all zero",
               instr_valid, halted, instr, instr_pc, fetch_cnt, im_addr);
    end
    exp_q.delete();
    hs_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_pc(32'h3000);
    repeat (3) cycle();
    instr_ready = 1'b0;
    n_checks++;
    if (instr_pc !== 32'h3004 || fetch_cnt !== 32'd1) begin
      n_fail++; $display("FAIL post_reset_stream: got pc=%h cnt=%0d expected pc=00003004 cnt=1", instr_pc, fetch_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    hs_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_halt();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_seq.md
IFU_SEQ -- requirements
Module: ifu_seq

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port im_addr, output, 10, word address to instruction memory, always equal to fpc[11:2].
REQ-004 SHALL provide port im_dout, input, 32, combinational read data from instruction memory for im_addr.
REQ-005 SHALL provide port instr, output, 32, registered instruction presented downstream.
REQ-006 SHALL provide port instr_pc, output, 32, byte PC of instr.
REQ-007 SHALL provide port instr_valid, output, 1, instr/instr_pc hold a valid word.
REQ-008 SHALL provide port instr_ready, input, 1, downstream accepts instr this cycle.
REQ-009 SHALL provide port redirect, input, 1, single-cycle branch/jump request.
REQ-010 SHALL provide port redirect_pc, input, 32, target byte PC for redirect.
REQ-011 SHALL provide port fetch_cnt, output, 32, count of completed handshakes (instr_valid & instr_ready).
REQ-012 SHALL provide port halted, output, 1, sequencer in HALT state.

Function
REQ-013 SHALL implement states IDLE, RUN, HALT; IDLE -> RUN unconditionally on first clock after rst_n deasserts.
REQ-014 SHALL hold internal fetch PC fpc, 32 bits; im_addr = fpc[11:2] combinationally in every state.
REQ-015 In RUN, load condition = !instr_valid | instr_ready; on load: instr<=im_dout, instr_pc<=fpc, instr_valid<=1, fpc<=fpc+4.
REQ-016 When instr_valid=1 and instr_ready=0 (no redirect), instr, instr_pc, instr_valid, fpc SHALL hold unchanged.
REQ-017 When instr_valid=1, instr_ready=1 and no load occurs (IDLE/HALT), instr_valid SHALL clear next cycle.
REQ-018 Sustained throughput SHALL be one instruction per cycle while instr_ready=1; fetch-to-valid latency one cycle.
REQ-019 redirect=1 SHALL take priority over load: fpc<={redirect_pc[31:2],2'b00}, instr_valid<=0 (flush), no load that cycle.
REQ-020 A handshake coincident with redirect SHALL still count in fetch_cnt; flushed unaccepted word SHALL not count.
REQ-021 fpc SHALL increment modulo 2^32; im_addr wraps 0x3FF -> 0x000 naturally (0x00003FFC+4 -> fpc 0x00004000, im_addr 0).
REQ-022 fetch_cnt SHALL increment by 1 per handshake, wrapping 0xFFFFFFFF -> 0.
REQ-023 redirect in HALT SHALL apply REQ-019 and transition to RUN; redirect in IDLE SHALL update fpc and still enter RUN.

Reset
REQ-024 While rst_n=0: state IDLE, fpc=0x00003000, instr=0, instr_pc=0, instr_valid=0, fetch_cnt=0, halted=0.
REQ-025 Reset assertion mid-operation SHALL clear all state immediately regardless of clk; pending redirect or handshake is discarded.

Configuration
REQ-026 Macro IFU_SEQ_HALT_EN SHALL, when defined, transition RUN -> HALT on loading im_dout==32'h0000000C (syscall); the syscall word is presented normally, no further loads in HALT, halted=1.
REQ-027 Without IFU_SEQ_HALT_EN, 32'h0000000C SHALL be an ordinary instruction, HALT unreachable, halted tied 0.

Verification
REQ-028 Reset, release, instr_ready=1, memory words W0..W3 at 0x3000.. -> instr_valid rises 2nd cycle after release with instr_pc 0x3000, then 0x3004, 0x3008 consecutive cycles.
REQ-029 instr_ready=0 for 3 cycles with instr_valid=1 -> instr, instr_pc, im_addr stable; fetch_cnt unchanged; resumes with next PC on ready=1.
REQ-030 redirect=1, redirect_pc=0x00003107 while stalled -> next cycle instr_valid=0, im_addr=0x041; following cycle instr_pc=0x00003104.
REQ-031 redirect to 0x00003FFC, ready=1 -> instr_pc 0x3FFC then 0x4000 with im_addr 0x000 returning word at index 0.
REQ-032 With IFU_SEQ_HALT_EN, syscall at 0x300C -> presented once, halted=1, instr_valid=0 after handshake, fetch_cnt=4; redirect 0x3000 -> RUN resumes. Without macro, fetch continues to 0x3010.
REQ-033 rst_n pulsed low mid-stream asynchronously -> outputs return to REQ-024 values before next clk edge.
